// File: rtl/rvx_core_alu_arbiter_pkg.sv
// Shared widths, port count and ALU funct3 encodings for the ALU arbiter slice.
package rvx_core_alu_arbiter_pkg;

  localparam int DATA_W            = 32;
  localparam int RVX_ALU_ARB_PORTS = 2;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_funct3_e;

endpackage

// File: rtl/rvx_core_alu_arbiter_alu.sv
// Combinational core ALU: op[3] selects SUB/SRA, op[2:0] is funct3.
module rvx_core_alu
  import rvx_core_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [SH_W-1:0]   shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SH_W-1:0];

  // SRA is a separate statement so the signed shift is not coerced to unsigned.
  always_comb begin
    y = '0;
    case (alu_funct3_e'(op[2:0]))
      F3_ADD:  y = op[3] ? (a - b) : (a + b);
      F3_SLL:  y = a << shamt;
      F3_SLT:  y = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      F3_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
      F3_XOR:  y = a ^ b;
      F3_SR: begin
        if (op[3]) y = a_s >>> shamt;
        else       y = a >> shamt;
      end
      F3_OR:   y = a | b;
      F3_AND:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rvx_core_alu_arbiter.sv
// Two-port arbiter sharing one core ALU; results are held in a single
// output register and returned to the requester that issued them.
module rvx_core_alu_arbiter
  import rvx_core_alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic              req0_sel,
  input  logic [DATA_W-1:0] req0_rs1,
  input  logic [DATA_W-1:0] req0_rs2,
  input  logic [DATA_W-1:0] req0_imm,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic              req1_sel,
  input  logic [DATA_W-1:0] req1_rs1,
  input  logic [DATA_W-1:0] req1_rs2,
  input  logic [DATA_W-1:0] req1_imm,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              busy
);

  logic              full;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] result_q;

  logic              rsp_fire;
  logic              slot_free;
  logic              grant;
  logic              accept;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;

  // Only the owning response port can drain the slot.
  assign rsp_fire  = full && (owner ? rsp1_ready : rsp0_ready);
  assign slot_free = !full || rsp_fire;

  always_comb begin
    grant = 1'b0;
    if (FIXED_PRIORITY) begin
      grant = !req0_valid;
    end else if (req0_valid && req1_valid) begin
      grant = !last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = slot_free && req0_valid && !grant;
  assign req1_ready = slot_free && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  assign alu_op = grant ? req1_op  : req0_op;
  assign alu_a  = grant ? req1_rs1 : req0_rs1;
  assign alu_b  = grant ? (req1_sel ? req1_rs2 : req1_imm)
                        : (req0_sel ? req0_rs2 : req0_imm);

  rvx_core_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Result register stage: accept overrides a same-cycle drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full       <= 1'b0;
      owner      <= 1'b0;
      result_q   <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      full       <= 1'b1;
      owner      <= grant;
      result_q   <= alu_y;
      last_grant <= grant;
    end else if (rsp_fire) begin
      full       <= 1'b0;
    end
  end

  assign rsp0_valid = full && !owner;
  assign rsp1_valid = full &&  owner;
  assign rsp_result = result_q;
  assign busy       = full;

endmodule

// File: tb/tb_rvx_core_alu_arbiter.sv
// Directed bench for rvx_core_alu_arbiter: a vector table on port 0 plus
// sequences for contention, backpressure, fixed priority and async reset.
module tb_rvx_core_alu_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic        req0_sel, req1_sel;
  logic [31:0] req0_rs1, req0_rs2, req0_imm;
  logic [31:0] req1_rs1, req1_rs2, req1_imm;
  logic        rsp0_ready, rsp1_ready;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp_result;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy;
  logic [31:0] fp_rsp_result;

  int tests  = 0;
  int errors = 0;

  rvx_core_alu_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_sel(req0_sel),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_sel(req1_sel),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .busy(busy)
  );

  rvx_core_alu_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op), .req0_sel(req0_sel),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op), .req1_sel(req1_sel),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(fp_rsp_result), .busy(fp_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic        sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req0(input logic [3:0] op, input logic sel, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm);
    req0_op = op; req0_sel = sel; req0_rs1 = rs1; req0_rs2 = rs2; req0_imm = imm;
  endtask

  task automatic set_req1(input logic [3:0] op, input logic sel, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm);
    req1_op = op; req1_sel = sel; req1_rs1 = rs1; req1_rs2 = rs2; req1_imm = imm;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b1, 32'd5,        32'd7,        32'd0,        32'd12};
    vecs[1]  = '{4'b1000, 1'b1, 32'd10,       32'd3,        32'd0,        32'd7};
    vecs[2]  = '{4'b0100, 1'b1, 32'h000000F0, 32'h0000000F, 32'd0,        32'h000000FF};
    vecs[3]  = '{4'b0010, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1};
    vecs[4]  = '{4'b0011, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0};
    vecs[5]  = '{4'b0000, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0};
    vecs[6]  = '{4'b0001, 1'b1, 32'd1,        32'd33,       32'd0,        32'd2};
    vecs[7]  = '{4'b0101, 1'b1, 32'h80000000, 32'd4,        32'd0,        32'h08000000};
    vecs[8]  = '{4'b1101, 1'b0, 32'h80000000, 32'd9,        32'd4,        32'hF8000000};
    vecs[9]  = '{4'b0110, 1'b1, 32'h000000F0, 32'h0000000F, 32'd0,        32'h000000FF};
    vecs[10] = '{4'b0111, 1'b1, 32'h000000F0, 32'h0000003C, 32'd0,        32'h00000030};
    vecs[11] = '{4'b0000, 1'b0, 32'd100,      32'd55,       32'hFFFFFFFF, 32'd99};

    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(4'd0, 1'b0, '0, '0, '0);
    set_req1(4'd0, 1'b0, '0, '0, '0);

    @(negedge clock); #1;
    check("reset_busy",       {31'd0, busy},       32'd0);
    check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("reset_result",     rsp_result,          32'd0);

    @(negedge clock);
    reset_n = 1'b1;

    // Vector table on port 0, one per cycle with the response port always ready.
    for (int i = 0; i < 12; i++) begin
      set_req0(vecs[i].op, vecs[i].sel, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      req0_valid = 1'b1;
      rsp0_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_req0_ready", i), {31'd0, req0_ready}, 32'd1);
      check($sformatf("vec%0d_req1_ready", i), {31'd0, req1_ready}, 32'd0);
      @(posedge clock); #1;
      check($sformatf("vec%0d_rsp0_valid", i), {31'd0, rsp0_valid}, 32'd1);
      check($sformatf("vec%0d_rsp1_valid", i), {31'd0, rsp1_valid}, 32'd0);
      check($sformatf("vec%0d_result", i),     rsp_result,          vecs[i].exp);
      @(negedge clock);
    end
    req0_valid = 1'b0;
    @(posedge clock); #1;
    check("drain_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);

    // Round-robin contention starting from a fresh reset.
    reset_n = 1'b0; #1; reset_n = 1'b1;
    set_req0(4'b1000, 1'b1, 32'd10, 32'd3, 32'd0);
    set_req1(4'b0100, 1'b1, 32'h000000F0, 32'h0000000F, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d_req0_ready", k), {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_req1_ready", k), {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clock); #1;
      check($sformatf("rr%0d_result", k),     rsp_result,          (k % 2 == 0) ? 32'd7 : 32'hFF);
      check($sformatf("rr%0d_rsp0_valid", k), {31'd0, rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_rsp1_valid", k), {31'd0, rsp1_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clock);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);

    // Backpressure on port 1 blocks a pending port-0 request.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req1(4'b1101, 1'b0, 32'h80000000, 32'd0, 32'd4);
    req1_valid = 1'b1;
    #1;
    check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clock); #1;
    check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    @(negedge clock);
    req1_valid = 1'b0;
    set_req0(4'b0000, 1'b1, 32'd5, 32'd7, 32'd0);
    req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_req0_ready", k), {31'd0, req0_ready}, 32'd0);
      @(posedge clock); #1;
      check($sformatf("bp%0d_result", k),     rsp_result,          32'hF8000000);
      check($sformatf("bp%0d_rsp1_valid", k), {31'd0, rsp1_valid}, 32'd1);
      @(negedge clock);
    end
    rsp1_ready = 1'b1;
    #1;
    check("bp_release_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clock); #1;
    check("bp_after_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("bp_after_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("bp_after_result",     rsp_result,          32'd12);
    @(negedge clock);

    // Fixed-priority instance: port 0 always wins while valid.
    req0_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    set_req0(4'b1000, 1'b1, 32'd10, 32'd3, 32'd0);
    set_req1(4'b0100, 1'b1, 32'h000000F0, 32'h0000000F, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("fp%0d_req0_ready", k), {31'd0, fp_req0_ready}, 32'd1);
      check($sformatf("fp%0d_req1_ready", k), {31'd0, fp_req1_ready}, 32'd0);
      @(posedge clock); #1;
      check($sformatf("fp%0d_rsp0_valid", k), {31'd0, fp_rsp0_valid}, 32'd1);
      check($sformatf("fp%0d_result", k),     fp_rsp_result,          32'd7);
      @(negedge clock);
    end
    req0_valid = 1'b0;
    #1;
    check("fp_drop_req1_ready", {31'd0, fp_req1_ready}, 32'd1);
    @(posedge clock); #1;
    check("fp_drop_rsp1_valid", {31'd0, fp_rsp1_valid}, 32'd1);
    check("fp_drop_result",     fp_rsp_result,          32'hFF);
    @(negedge clock);

    // Asynchronous reset while a port-0 result is held.
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    set_req0(4'b0000, 1'b1, 32'd5, 32'd7, 32'd0);
    req0_valid = 1'b1;
    @(posedge clock); #1;
    check("ar_rsp0_valid_before", {31'd0, rsp0_valid}, 32'd1);
    req0_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("ar_busy",       {31'd0, busy},       32'd0);
    check("ar_result",     rsp_result,          32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    set_req1(4'b0100, 1'b1, 32'h000000F0, 32'h0000000F, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    check("ar_first_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("ar_first_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clock); #1;
    check("ar_first_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("ar_first_result",     rsp_result,          32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/rvx_core_alu_arbiter.md
# rvx_core_alu_arbiter

Shares one `rvx_core_alu` instance between two independent requesters: port 0 is the integer pipeline and port 1 is an auxiliary unit, such as CSR or debug address generation. Each requester sends an ALU operation over a valid/ready request channel. The block arbitrates between the two, evaluates the winning operation combinationally, and holds the result in a single output register. Each result returns on the response channel of the requester that issued it.

## Interface
- `FIXED_PRIORITY`, default 0: 0 selects round-robin arbitration; 1 gives port 0 strict priority.
- `clock`  in  1  single clock for the block; all state is updated on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  the requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  the operation is accepted this cycle.
- `req0_op` / `req1_op`  in  4  ALU operation code: bit 3 selects SUB/SRA; bits 2:0 are funct3.
- `req0_sel` / `req1_sel`  in  1  second-operand select: 1 selects rs2, 0 selects the immediate.
- `req0_rs1`, `req0_rs2`, `req0_imm` / the same for `req1_*`  in  32 each  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  a result is held for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  the requester takes the result.
- `rsp_result`  out  32  contents of the result register, shared by both response ports.
- `busy`  out  1  the result register is full.

## Operation
- **State:** `full` (1 bit), `owner` (1 bit), `result_q` (32 bits), `last_grant` (1 bit).
- **Reset values:** `full`=0, `owner`=0, `result_q`=0, `last_grant`=1. As a result, port 0 wins the first contention after reset.
- **Response drain:** `rsp_fire` = `full` && ((`owner`==0 && `rsp0_ready`) || (`owner`==1 && `rsp1_ready`)).
- **Slot availability:** `slot_free` = !`full` || `rsp_fire`.
- **Grant, round-robin** (`FIXED_PRIORITY`=0):
  - Only one valid: grant that port.
  - Both valid: grant the port != `last_grant`.
- **Grant, fixed priority** (`FIXED_PRIORITY`=1): port 0 whenever `req0_valid`, otherwise port 1.
- **Ready outputs:** `reqN_ready` = `slot_free` && `reqN_valid` && grant==N. At most one ready is high per cycle.
- **Accept** (some `reqN_ready` high): the selected operands drive the ALU. On the clock edge:
  - `result_q` ← ALU output
  - `owner` ← N
  - `full` ← 1
  - `last_grant` ← N
- **Drain only** (`rsp_fire` with no accept): `full` ← 0; `result_q` and `owner` hold.
- **Response outputs:** `rspN_valid` = `full` && `owner`==N. `rsp_result` = `result_q`. `busy` = `full`.
- **ALU semantics:** unchanged from the core ALU.
  - ADD/SUB: 32-bit wrap.
  - Shift amount: operand[4:0].
  - SLT: signed compare; SLTU: unsigned compare.
  - Results zero-extended to 32 bits.
- **Ready does not depend on valid from the other port's response.** A ready asserted to a non-owner response port is ignored.

## Timing
- **Latency:** a request accepted at edge k has its result valid at edge k (visible in cycle k+1).
- **Throughput:** one operation per cycle while the owning `rspN_ready` is held high.
- **Back-to-back ownership change:** a drain and an accept for the other port in the same cycle are legal. `owner` switches with no bubble.
- **Full, owner not ready:** both `reqN_ready` are 0 and the state holds. Request inputs must stay stable while valid and not ready.
- **Combinational paths:**
  - `rspN_ready` → `reqN_ready` (through `slot_free`).
  - `reqN_valid` → `reqM_ready` (arbitration).
  - There is no combinational path from request to response.
- **Reset mid-operation:** asserting `reset_n`=0 clears `full` asynchronously. Any held result is discarded without a response, and every output returns to its reset value immediately.
- **Deassertion:** the first accept can occur on the first rising edge after `reset_n` goes high.

## Structure
- ALU operation encodings come from `rvx_core_constants.vh`. Add a `RVX_ALU_ARB_PORTS` define (value 2) there; do not add new encodings.
- Exactly one sub-module: `rvx_core_alu`, instantiated once. It is fed by a 2:1 operand mux on the grant.
- The arbiter, result register and response demux live in this module.

## Test plan
- **Single ADD on port 0:** after reset, req0: op=0000, sel=1, rs1=5, rs2=7, with `rsp0_ready`=1.
  - `req0_ready`=1 in the same cycle.
  - Next cycle `rsp0_valid`=1 and `rsp_result`=12.
  - `rsp1_valid` stays 0.
- **Round-robin contention:** both ports valid for 4 cycles. Port 0 sends SUB 10−3 (op=1000); port 1 sends XOR 0xF0^0x0F. Both response ports are ready.
  - Grants alternate 0,1,0,1.
  - Results alternate 7 and 0xFF, with no idle cycle.
- **Backpressure:** port 1 sends SRA on 0x80000000 by imm=4 (sel=0, op=1101), with `rsp1_ready`=0 for 3 cycles.
  - `rsp_result`=0xF8000000 holds.
  - A pending req0 sees `req0_ready`=0 until `rsp1_ready` rises.
  - req0 is then accepted in that same cycle.
- **Fixed priority** (`FIXED_PRIORITY`=1): both ports valid continuously.
  - Port 0 is granted every cycle.
  - Port 1 is granted in the first cycle after `req0_valid` drops.
- **Compare boundaries:** SLT −1 vs 1 gives 1; SLTU 0xFFFFFFFF vs 1 gives 0; ADD 0xFFFFFFFF+1 gives 0.
- **Async reset while full:** pull `reset_n` low mid-cycle while `rsp0_valid`=1.
  - `rsp0_valid` and `busy` drop before the next edge.
  - After release, port 0 wins the first contention.
